spi_coef_bank: RTL and testbench

//  Parametrised SPI-slave coefficient register bank. Next generation of the modulator config port.

---
 rtl/spi_coef_bank.sv | 200 ++++++++++++++++++++
 tb/tb_spi_coef_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_coef_bank.sv
// SPI-slave coefficient bank: oversampled SPI port, shadow/active register pairs,
// atomic commit, MISO read-back and frame-length error reporting.
module spi_coef_bank #(
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 20,
    parameter int                PAD_W       = 4,
    parameter int                NUM_REGS    = 8,
    parameter int                BASE_ADDR   = 1,
    parameter logic [ADDR_W-1:0] COMMIT_ADDR = 7'h7F,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       spi_sclk,
    input  logic                       spi_ss_n,
    input  logic                       spi_mosi,
    output logic                       spi_miso,
    output logic                       spi_miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] coef_out,
    output logic                       commit_pulse,
    output logic                       frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W + PAD_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int RD_W    = $clog2(DATA_W + 1);
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  RD_LOAD   = CNT_W'(ADDR_W);
    localparam logic [RD_W-1:0]   DATA_CNT  = RD_W'(DATA_W);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   NREG_A    = (ADDR_W + 1)'(NUM_REGS);

    if (NUM_REGS > 2**ADDR_W - 2) begin : g_bad_num_regs
        $error("spi_coef_bank: NUM_REGS must be <= 2**ADDR_W-2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_coef_bank: SYNC_STAGES must be >= 2");
    end

    // IDLE: wait ss_n fall | SHIFT: collect bits, drive read data | DONE: evaluate frame
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sclk_sync, ss_sync, mosi_sync;
    logic                     sclk_prev, ss_prev;
    logic [FRAME_W-1:0]       shift_reg;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     over_len;
    logic [DATA_W-1:0]        shadow [NUM_REGS];
    logic [DATA_W-1:0]        active [NUM_REGS];
    logic [DATA_W-1:0]        rd_reg;
    logic [RD_W-1:0]          rd_cnt;
    logic                     rd_active;

    logic                     sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [FRAME_W-1:0]       shift_next;
    logic                     f_rw, e_rw;
    logic [ADDR_W-1:0]        f_addr, e_addr;
    logic [DATA_W-1:0]        f_data;

    function automatic logic reg_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] rel;
        rel = a - BASE_A;
        return (a >= BASE_A) && ({1'b0, rel} < NREG_A);
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a - BASE_A);
    endfunction

    assign sclk_rise  =  sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall  = ~sclk_sync[SYNC_STAGES-1] &  sclk_prev;
    assign ss_rise    =  ss_sync[SYNC_STAGES-1]   & ~ss_prev;
    assign ss_fall    = ~ss_sync[SYNC_STAGES-1]   &  ss_prev;
    assign shift_next = {shift_reg[FRAME_W-2:0], mosi_sync[SYNC_STAGES-1]};

    // Early view taken on the rise that completes {rw, addr}, so read data is ready for the next fall.
    assign e_rw   = shift_next[ADDR_W];
    assign e_addr = shift_next[ADDR_W-1:0];
    assign f_rw   = shift_reg[FRAME_W-1];
    assign f_addr = shift_reg[FRAME_W-2 -: ADDR_W];
    assign f_data = shift_reg[PAD_W +: DATA_W];

    // Sync chains reset low so an ss_n held low across reset release never looks like a frame start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ss_prev   <= ss_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            over_len     <= 1'b0;
            rd_reg       <= '0;
            rd_cnt       <= '0;
            rd_active    <= 1'b0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            commit_pulse <= 1'b0;
            frame_err    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            commit_pulse <= 1'b0;
            frame_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state     <= SHIFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        over_len  <= 1'b0;
                        rd_active <= 1'b0;
                        rd_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state       <= DONE;
                        spi_miso    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                        rd_active   <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            if (bit_cnt == FRAME_CNT) begin
                                over_len <= 1'b1;
                            end else begin
                                shift_reg <= shift_next;
                                bit_cnt   <= bit_cnt + 1'b1;
                                if (bit_cnt == RD_LOAD && !e_rw && reg_hit(e_addr)) begin
                                    rd_reg    <= shadow[reg_idx(e_addr)];
                                    rd_active <= 1'b1;
                                    rd_cnt    <= '0;
                                end
                            end
                        end
                        if (sclk_fall && rd_active) begin
                            if (rd_cnt == DATA_CNT) begin
                                spi_miso    <= 1'b0;
                                spi_miso_oe <= 1'b0;
                                rd_active   <= 1'b0;
                            end else begin
                                spi_miso    <= rd_reg[DATA_W-1];
                                spi_miso_oe <= 1'b1;
                                rd_reg      <= {rd_reg[DATA_W-2:0], 1'b0};
                                rd_cnt      <= rd_cnt + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (bit_cnt == FRAME_CNT && !over_len) begin
                        if (f_rw && reg_hit(f_addr)) begin
                            shadow[reg_idx(f_addr)] <= f_data;
                        end else if (f_rw && f_addr == COMMIT_ADDR) begin
                            active       <= shadow;
                            commit_pulse <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                    // A one-clock ss_n high gap lands its falling edge here.
                    if (ss_fall) begin
                        state     <= SHIFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        over_len  <= 1'b0;
                        rd_active <= 1'b0;
                        rd_cnt    <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_coef
        assign coef_out[i*DATA_W +: DATA_W] = active[i];
    end

endmodule

// File: tb/tb_spi_coef_bank.sv
// Testbench for spi_coef_bank: SPI master driver, array-based reference model,
// and scoreboard monitors for commit/error pulses and MISO read-back.
module tb_spi_coef_bank;

    localparam int NREG = 8;
    localparam int DW   = 20;
    localparam int CW   = NREG * DW;
    localparam int HALF = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          spi_sclk = 1'b0;
    logic          spi_ss_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso, spi_miso_oe, commit_pulse, frame_err;
    logic [CW-1:0] coef_out;

    spi_coef_bank dut (
        .clock        (clock),
        .reset        (reset),
        .spi_sclk     (spi_sclk),
        .spi_ss_n     (spi_ss_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .coef_out     (coef_out),
        .commit_pulse (commit_pulse),
        .frame_err    (frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            is_commit;
        logic [CW-1:0] coef;
    } ev_t;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] m_shadow [NREG];
    logic [DW-1:0] m_active [NREG];
    ev_t           ev_q [$];
    logic [DW-1:0] rd_q [$];

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] pack_active();
        logic [CW-1:0] p;
        for (int i = 0; i < NREG; i++) p[i*DW +: DW] = m_active[i];
        return p;
    endfunction

    function automatic logic [31:0] mk(input logic rw, input logic [6:0] a,
                                       input logic [DW-1:0] d, input logic [3:0] p);
        return {rw, a, d, p};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        ev_q.delete();
        rd_q.delete();
    endtask

    // Reference behaviour of one frame, applied before the frame is clocked out.
    task automatic model(input logic [31:0] fr, input int n);
        logic          rw;
        logic [6:0]    a;
        logic [DW-1:0] d;
        ev_t           e;
        rw = fr[31];
        a  = fr[30:24];
        d  = fr[23:4];
        if (n != 32) begin
            e.is_commit = 1'b0;
            e.coef      = '0;
            ev_q.push_back(e);
        end else if (rw) begin
            if (a >= 1 && a <= NREG) begin
                m_shadow[a - 1] = d;
            end else if (a == 7'h7F) begin
                m_active    = m_shadow;
                e.is_commit = 1'b1;
                e.coef      = pack_active();
                ev_q.push_back(e);
            end
        end else if (a >= 1 && a <= NREG) begin
            rd_q.push_back(m_shadow[a - 1]);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = w[i];
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
    endtask

    task automatic frame(input logic [63:0] w, input int n, input int gap);
        model(w[31:0], n);
        spi_ss_n = 1'b0;
        wait_clk(4);
        send_bits(w, n);
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(gap);
    endtask

    // Pulse monitor: every commit/error pulse must match the next expected event.
    logic [CW-1:0] prev_coef = '0;
    always @(negedge clock) begin
        ev_t e;
        if (reset) begin
            if (coef_out !== prev_coef && !commit_pulse) begin
                vectors++;
                miscompares++;
                $display("FAIL coef_change: got %0h with no commit_pulse, required %0h", coef_out, prev_coef);
            end
            if (commit_pulse || frame_err) begin
                if (ev_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got commit=%0b err=%0b, required no pulse",
                             commit_pulse, frame_err);
                end else begin
                    e = ev_q.pop_front();
                    check("pulse_kind", {commit_pulse, frame_err}, e.is_commit ? 2'b10 : 2'b01);
                    if (e.is_commit) check("coef_out", coef_out, e.coef);
                end
            end
        end
        prev_coef = coef_out;
    end

    // Read monitor: samples MISO/oe where the master samples (SCLK rise).
    int            bitpos = 0;
    int            oe_first = 0;
    int            oe_cnt = 0;
    bit            capturing = 1'b0;
    logic [DW-1:0] cap = '0;

    task automatic finish_read();
        logic [DW-1:0] exp;
        capturing = 1'b0;
        if (rd_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_read: got oe high %0d bits data %0h, required oe low", oe_cnt, cap);
        end else begin
            exp = rd_q.pop_front();
            check("rd_data", cap, exp);
            check("rd_oe_start", oe_first, 8);
            check("rd_oe_len", oe_cnt, DW);
        end
    endtask

    always @(posedge spi_sclk or negedge spi_ss_n or posedge spi_ss_n) begin
        if (!spi_ss_n && !spi_sclk) begin
            bitpos    = 0;
            oe_cnt    = 0;
            capturing = 1'b0;
        end else if (spi_sclk) begin
            if (spi_miso_oe) begin
                if (oe_cnt == 0) oe_first = bitpos;
                cap       = {cap[DW-2:0], spi_miso};
                oe_cnt    = oe_cnt + 1;
                capturing = 1'b1;
            end else if (capturing) begin
                finish_read();
            end
            bitpos = bitpos + 1;
        end else if (capturing) begin
            finish_read();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [63:0] w64;
        int          n, kind;
        model_reset();
        wait_clk(5);
        check("rst_coef", coef_out, '0);
        check("rst_outputs", {spi_miso, spi_miso_oe, commit_pulse, frame_err}, 4'b0000);
        reset = 1'b1;
        wait_clk(5);

        frame(mk(1'b1, 7'h03, 20'h12345, 4'h0), 32, 10);
        wait_clk(10);
        check("t1_coef_unchanged", coef_out, '0);

        frame(mk(1'b1, 7'h7F, 20'($urandom), 4'h0), 32, 10);
        wait_clk(10);
        check("t2_reg2", coef_out[40 +: 20], 20'h12345);

        frame(mk(1'b0, 7'h03, 20'($urandom), 4'h0), 32, 10);

        w = mk(1'b1, 7'h01, 20'hABCDE, 4'h0);
        frame({33'b0, w[31:1]}, 31, 10);
        frame({31'b0, w, 1'b0}, 33, 10);
        frame(mk(1'b0, 7'h01, 20'h0, 4'h0), 32, 10);

        frame(mk(1'b1, 7'h02, 20'hAAAAA, 4'h5), 32, 10);
        frame(mk(1'b1, 7'h7F, 20'h0, 4'h0), 32, 10);
        w = mk(1'b1, 7'h04, 20'h55555, 4'h0);
        spi_ss_n = 1'b0;
        wait_clk(4);
        send_bits({48'b0, w[31:16]}, 16);
        reset = 1'b0;
        model_reset();
        wait_clk(4);
        check("t5_reset_coef", coef_out, '0);
        check("t5_reset_oe", {spi_miso, spi_miso_oe}, 2'b00);
        reset = 1'b1;
        send_bits({48'b0, w[15:0]}, 16);
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(10);
        frame(mk(1'b1, 7'h01, 20'h0F0F0, 4'h3), 32, 10);
        frame(mk(1'b1, 7'h7F, 20'h0, 4'h0), 32, 10);
        frame(mk(1'b0, 7'h02, 20'h0, 4'h0), 32, 10);

        frame(mk(1'b1, 7'h00, 20'hFFFFF, 4'h0), 32, 10);
        frame(mk(1'b1, 7'h09, 20'hFFFFF, 4'h0), 32, 10);
        frame(mk(1'b1, 7'h06, 20'h13579, 4'h0), 32, 1);
        frame(mk(1'b1, 7'h7F, 20'h0, 4'h0), 32, 10);

        for (int i = 0; i < 50; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: frame(mk(1'b1, 7'($urandom_range(1, 8)), 20'($urandom), 4'($urandom)),
                                  32, $urandom_range(1, 12));
                4: frame(mk(1'b1, ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom_range(9, 126)),
                            20'($urandom), 4'($urandom)), 32, $urandom_range(1, 12));
                5, 6: frame(mk(1'b1, 7'h7F, 20'($urandom), 4'($urandom)), 32, $urandom_range(1, 12));
                7: frame(mk(1'b0, 7'($urandom_range(1, 8)), 20'($urandom), 4'($urandom)),
                         32, $urandom_range(1, 12));
                8: frame(mk(1'b0, ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom_range(9, 127)),
                            20'($urandom), 4'($urandom)), 32, $urandom_range(1, 12));
                default: begin
                    w64 = {$urandom, $urandom};
                    n   = $urandom_range(0, 40);
                    if (n == 32) n = 31;
                    if (n > 0) w64[n - 1] = 1'b1;
                    frame(w64, n, $urandom_range(1, 12));
                end
            endcase
        end

        wait_clk(50);
        check("ev_q_drained", 32'(ev_q.size()), '0);
        check("rd_q_drained", 32'(rd_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
